// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the modular arithmetic datapath.
//   quarter_state_t : state encoding of the sequential modular divider
//   cnt_width()     : width of a counter that must hold values 0..shift
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } quarter_state_t;

    function automatic int cnt_width(input int shift);
        return (shift < 1) ? 1 : $clog2(shift + 1);
    endfunction

endpackage

// File: rtl/mod_halve_step.sv
// One modular halving step for an odd modulus: y = x * 2^-1 mod q.
// Combinational. Requires x < q and q odd; the result is then < q.
//   x : operand   (BITWIDTH)
//   q : modulus   (BITWIDTH, odd)
//   y : result    (BITWIDTH)
module mod_halve_step #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] y
);

    // One extra bit so x+q cannot wrap when q = 2^BITWIDTH-1.
    logic [BITWIDTH:0] sum;

    always_comb begin
        sum = {1'b0, x};
        if (x[0]) begin
            sum = {1'b0, x} + {1'b0, q};
        end
        y = BITWIDTH'(sum >> 1);
    end

endmodule

// File: rtl/mod_quarter_seq.sv
// Sequential modular divider by 2^SHIFT: oData = iData * (2^SHIFT)^-1 mod iQ.
// One modular halving per enabled cycle, start/valid handshake.
//   iClk   : clock, rising edge
//   iRstN  : asynchronous active-low reset
//   iEn    : clock enable, low freezes everything
//   iClr   : synchronous clear (only with iEn), beats iStart
//   iStart : start request, sampled with iData/iQ in IDLE or DONE
//   iData  : operand (must be < iQ)
//   iQ     : modulus (must be odd)
//   oBusy  : high while running
//   oValid : result valid, held until next accepted start or clear
//   oErr   : illegal operands, qualified by oValid
//   oData  : result
module mod_quarter_seq
    import mod_arith_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int SHIFT    = 2
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iStart,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    output logic                oBusy,
    output logic                oValid,
    output logic                oErr,
    output logic [BITWIDTH-1:0] oData
);

    localparam int CW = cnt_width(SHIFT);

    quarter_state_t      state;
    logic [BITWIDTH-1:0] x_reg;
    logic [BITWIDTH-1:0] q_reg;
    logic [BITWIDTH-1:0] x_next;
    logic [CW-1:0]       cnt;
    logic                operands_ok;

    mod_halve_step #(
        .BITWIDTH(BITWIDTH)
    ) u_halve (
        .x(x_reg),
        .q(q_reg),
        .y(x_next)
    );

    assign operands_ok = iQ[0] && (iData < iQ);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state  <= IDLE;
            x_reg  <= '0;
            q_reg  <= '0;
            cnt    <= '0;
            oBusy  <= 1'b0;
            oValid <= 1'b0;
            oErr   <= 1'b0;
            oData  <= '0;
        end else if (iEn) begin
            if (iClr) begin
                state  <= IDLE;
                x_reg  <= '0;
                q_reg  <= '0;
                cnt    <= '0;
                oBusy  <= 1'b0;
                oValid <= 1'b0;
                oErr   <= 1'b0;
                oData  <= '0;
            end else if (iStart && (state != RUN)) begin
                x_reg  <= iData;
                q_reg  <= iQ;
                cnt    <= CW'(SHIFT);
                oData  <= '0;
                if (operands_ok) begin
                    state  <= RUN;
                    oBusy  <= 1'b1;
                    oValid <= 1'b0;
                    oErr   <= 1'b0;
                end else begin
                    // Illegal operands skip RUN and report immediately.
                    state  <= DONE;
                    oBusy  <= 1'b0;
                    oValid <= 1'b1;
                    oErr   <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        x_reg <= x_next;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state  <= DONE;
                            oBusy  <= 1'b0;
                            oValid <= 1'b1;
                            oData  <= x_next;
                        end
                    end
                    IDLE, DONE: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_quarter_seq.sv
module tb_mod_quarter_seq;

    logic       iClk = 1'b0;
    logic       iRstN = 1'b0;
    logic       iEn = 1'b1;
    logic       iClr = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iData = '0;
    logic [7:0] iQ = '0;
    logic       oBusy;
    logic       oValid;
    logic       oErr;
    logic [7:0] oData;

    int vectors = 0;
    int miscompares = 0;

    mod_quarter_seq #(
        .BITWIDTH(8),
        .SHIFT(2)
    ) dut (
        .iClk(iClk),
        .iRstN(iRstN),
        .iEn(iEn),
        .iClr(iClr),
        .iStart(iStart),
        .iData(iData),
        .iQ(iQ),
        .oBusy(oBusy),
        .oValid(oValid),
        .oErr(oErr),
        .oData(oData)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic busy, input logic valid,
                             input logic err, input logic [7:0] data);
        check({tag, ".busy"},  {31'd0, oBusy},  {31'd0, busy});
        check({tag, ".valid"}, {31'd0, oValid}, {31'd0, valid});
        check({tag, ".err"},   {31'd0, oErr},   {31'd0, err});
        check({tag, ".data"},  {24'd0, oData},  {24'd0, data});
    endtask

    // Start an operation and walk it to DONE, checking the cycle-by-cycle handshake.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [7:0] q,
                          input logic [7:0] exp_data, input logic exp_err);
        iData  = d;
        iQ     = q;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        iData  = 8'hAA;
        iQ     = 8'h55;
        if (exp_err) begin
            check_out({tag, ".acc"}, 1'b0, 1'b1, 1'b1, 8'd0);
        end else begin
            check_out({tag, ".acc"}, 1'b1, 1'b0, 1'b0, 8'd0);
            step();
            check({tag, ".mid_valid"}, {31'd0, oValid}, 32'd0);
            step();
            check_out({tag, ".done"}, 1'b0, 1'b1, 1'b0, exp_data);
        end
    endtask

    initial begin
        int waited;

        // Reset state
        #2;
        check_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        iRstN = 1'b1;
        step();
        check_out("idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // Basic: 4*10 mod 23 = 17
        run_op("q23_d17", 8'd17, 8'd23, 8'd10, 1'b0);

        // Sweep of odd moduli, data = 40 mod q (back-to-back starts from DONE)
        run_op("q21_d19", 8'd19, 8'd21, 8'd10, 1'b0);
        run_op("q19_d2",  8'd2,  8'd19, 8'd10, 1'b0);
        run_op("q17_d6",  8'd6,  8'd17, 8'd10, 1'b0);
        run_op("q15_d10", 8'd10, 8'd15, 8'd10, 1'b0);

        // Wide carry path: 254 -> 127 -> (127+255)/2 = 191
        run_op("q255_d254", 8'd254, 8'd255, 8'd191, 1'b0);
        // 5 -> (5+13)/2=9 -> (9+13)/2=11
        run_op("q13_d5", 8'd5, 8'd13, 8'd11, 1'b0);
        // q=1 is legal, result 0
        run_op("q1_d0", 8'd0, 8'd1, 8'd0, 1'b0);

        // Illegal operands
        run_op("q22_even", 8'd5,  8'd22, 8'd0, 1'b1);
        run_op("d30_ge_q", 8'd30, 8'd23, 8'd0, 1'b1);
        run_op("d23_eq_q", 8'd23, 8'd23, 8'd0, 1'b1);
        // Recover normally after an error
        run_op("after_err", 8'd17, 8'd23, 8'd10, 1'b0);

        // Enable low for 3 cycles mid-RUN, plus iStart during RUN ignored
        iData = 8'd17; iQ = 8'd23; iStart = 1'b1;
        step();
        iStart = 1'b0;
        step();
        iEn = 1'b0;
        iClr = 1'b1;
        iStart = 1'b1; iData = 8'd5; iQ = 8'd13;
        step(); step(); step();
        check_out("frozen", 1'b1, 1'b0, 1'b0, 8'd0);
        iClr = 1'b0;
        iEn = 1'b1;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            if (oValid) break;
            step();
            waited++;
        end
        iStart = 1'b0;
        check("en_stall.wait", waited, 1);
        check_out("en_stall.done", 1'b0, 1'b1, 1'b0, 8'd10);

        // iEn low in DONE: start and clear ignored, outputs held
        iEn = 1'b0; iStart = 1'b1; iData = 8'd5; iQ = 8'd13;
        step(); step();
        iClr = 1'b1;
        step();
        iClr = 1'b0; iStart = 1'b0; iEn = 1'b1;
        check_out("done_frozen", 1'b0, 1'b1, 1'b0, 8'd10);
        step();
        check_out("done_hold", 1'b0, 1'b1, 1'b0, 8'd10);

        // Clear mid-RUN aborts, clear beats start
        iData = 8'd5; iQ = 8'd13; iStart = 1'b1;
        step();
        iStart = 1'b0;
        step();
        iClr = 1'b1; iStart = 1'b1;
        step();
        iClr = 1'b0; iStart = 1'b0;
        check_out("clr_run", 1'b0, 1'b0, 1'b0, 8'd0);
        step(); step();
        check_out("clr_stays_idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // Back-to-back start from DONE, then async reset in DONE
        run_op("b2b_a", 8'd5, 8'd13, 8'd11, 1'b0);
        run_op("b2b_b", 8'd254, 8'd255, 8'd191, 1'b0);
        #2;
        iRstN = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        iRstN = 1'b1;
        step();
        check_out("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        run_op("post_rst", 8'd17, 8'd23, 8'd10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
